fpu_op_sequencer: RTL and testbench

//  Command queue and issue controller between the FPU register bank and the FPU core.

---
 rtl/fpu_pkg.sv | 19 +
 rtl/fpu_cmd_fifo.sv | 57 +++++
 rtl/fpu_op_sequencer.sv | 132 +++++++++++++
 tb/tb_fpu_op_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared types for the FPU command sequencer: FSM states, the queued job record
// and the canned result returned when the core hangs.
package fpu_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } seq_state_t;

    localparam logic [31:0] FpuQnan = 32'h7FC0_0000;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [2:0]  sel;
    } fpu_cmd_t;

endpackage

// File: rtl/fpu_cmd_fifo.sv
// Synchronous FIFO of FPU jobs. Push is refused when full even if a pop happens
// in the same cycle; there is no bypass from push to pop.
module fpu_cmd_fifo
    import fpu_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  fpu_cmd_t               push_data,
    input  logic                   pop,
    output fpu_cmd_t               pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(Depth):0] count
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    fpu_cmd_t            mem_q [Depth];
    logic [PtrW-1:0]     wr_ptr_q;
    logic [PtrW-1:0]     rd_ptr_q;
    logic [CntW-1:0]     count_q;
    logic                do_push;
    logic                do_pop;

    assign full     = (count_q == CntW'(Depth));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;

    // Depth is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (do_push && !do_pop) begin
                count_q <= count_q + CntW'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/fpu_op_sequencer.sv
// Queues FPU jobs and issues them one at a time to the core, holding operands until
// data_valid (or a watchdog expiry) and returning each result on a valid/ready port.
module fpu_op_sequencer
    import fpu_pkg::*;
#(
    parameter int unsigned Depth   = 4,
    parameter int unsigned Timeout = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [31:0]            cmd_op1,
    input  logic [31:0]            cmd_op2,
    input  logic [2:0]             cmd_sel,
    output logic [31:0]            fpu_op1,
    output logic [31:0]            fpu_op2,
    output logic [2:0]             fpu_sel,
    output logic                   fpu_enable,
    input  logic [31:0]            fpu_result,
    input  logic                   fpu_data_valid,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [31:0]            res_data,
    output logic                   res_err,
    output logic                   busy,
    output logic [$clog2(Depth):0] cmd_count
);

    localparam logic [15:0] TimeoutW = 16'(Timeout);

    seq_state_t  state_q, state_d;
    fpu_cmd_t    cmd_q, cmd_d;
    fpu_cmd_t    fifo_head;
    logic [15:0] wd_q, wd_d;
    logic        enable_q, enable_d;
    logic        res_valid_q, res_valid_d;
    logic [31:0] res_data_q, res_data_d;
    logic        res_err_q, res_err_d;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;

    fpu_cmd_fifo #(
        .Depth(Depth)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (cmd_valid),
        .push_data('{op1: cmd_op1, op2: cmd_op2, sel: cmd_sel}),
        .pop      (pop),
        .pop_data (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (cmd_count)
    );

    assign cmd_ready  = ~fifo_full;
    assign fpu_op1    = cmd_q.op1;
    assign fpu_op2    = cmd_q.op2;
    assign fpu_sel    = cmd_q.sel;
    assign fpu_enable = enable_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_err    = res_err_q;
    assign busy       = ~fifo_empty | (state_q != StIdle);

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        wd_d        = wd_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_err_d   = res_err_q;
        pop         = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    cmd_d   = fifo_head;
                    wd_d    = '0;
                    state_d = StExec;
                end
            end
            StExec: begin
                wd_d = wd_q + 16'd1;
                // A result arriving on the expiry cycle still wins over the timeout.
                if (fpu_data_valid) begin
                    res_data_d  = fpu_result;
                    res_err_d   = 1'b0;
                    res_valid_d = 1'b1;
                    state_d     = StResp;
                end else if (wd_d == TimeoutW) begin
                    res_data_d  = FpuQnan;
                    res_err_d   = 1'b1;
                    res_valid_d = 1'b1;
                    state_d     = StResp;
                end
            end
            StResp: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Registered request: rises one cycle into EXEC, drops on the exit edge.
        enable_d = (state_q == StExec) && (state_d == StExec);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cmd_q       <= '0;
            wd_q        <= '0;
            enable_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            wd_q        <= wd_d;
            enable_q    <= enable_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_err_q   <= res_err_d;
        end
    end

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Bench for fpu_op_sequencer: queue/phase model checked every cycle, in-order result
// scoreboard, and hand-computed expectations for latency, fill, timeout and reset.
module tb_fpu_op_sequencer;
    import fpu_pkg::*;

    localparam int unsigned Depth   = 4;
    localparam int unsigned Timeout = 8;
    localparam int          Lat     = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_op1 = '0;
    logic [31:0] cmd_op2 = '0;
    logic [2:0]  cmd_sel = '0;
    logic [31:0] fpu_op1, fpu_op2;
    logic [2:0]  fpu_sel;
    logic        fpu_enable;
    logic [31:0] fpu_result;
    logic        fpu_data_valid;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [31:0] res_data;
    logic        res_err;
    logic        busy;
    logic [2:0]  cmd_count;

    logic        core_dv  = 1'b0;
    logic        inj_dv   = 1'b0;
    logic [31:0] core_res = '0;
    bit          hang     = 1'b0;

    assign fpu_data_valid = core_dv | inj_dv;
    assign fpu_result     = core_res;

    always #5 clk = ~clk;

    fpu_op_sequencer #(
        .Depth  (Depth),
        .Timeout(Timeout)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op1       (cmd_op1),
        .cmd_op2       (cmd_op2),
        .cmd_sel       (cmd_sel),
        .fpu_op1       (fpu_op1),
        .fpu_op2       (fpu_op2),
        .fpu_sel       (fpu_sel),
        .fpu_enable    (fpu_enable),
        .fpu_result    (fpu_result),
        .fpu_data_valid(fpu_data_valid),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .res_err       (res_err),
        .busy          (busy),
        .cmd_count     (cmd_count)
    );

    function automatic logic [31:0] core_fn(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] s);
        if (s == 3'd0 && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return (a ^ {b[15:0], b[31:16]}) + {29'd0, s};
    endfunction

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int got   = 0;
    logic [31:0] sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Core: captures operands on the first enable edge, result appears Lat cycles later.
    int ccnt  = 0;
    bit fired = 1'b0;
    always @(posedge clk) begin
        logic        en;
        logic [31:0] a, b;
        logic [2:0]  s;
        en = fpu_enable;
        a  = fpu_op1;
        b  = fpu_op2;
        s  = fpu_sel;
        #1;
        core_dv = 1'b0;
        if (!en) begin
            ccnt  = 0;
            fired = 1'b0;
        end else if (!fired) begin
            ccnt++;
            if (ccnt == Lat + 1 && !hang) begin
                core_dv  = 1'b1;
                core_res = core_fn(a, b, s);
                fired    = 1'b1;
            end
        end
    end

    // Model: job queue plus phase of the single in-flight job (0 idle, 1 exec, 2 resp).
    fpu_cmd_t    mq[$];
    fpu_cmd_t    mcur  = '0;
    int          mphase = 0;
    int          mecyc  = 0;
    logic [31:0] mres  = '0;
    logic        merr  = 1'b0;

    always @(posedge clk) begin
        bit accept;
        if (rst) begin
            mq.delete();
            mcur = '0; mphase = 0; mecyc = 0; mres = '0; merr = 1'b0;
        end else begin
            accept = cmd_valid && (mq.size() < Depth);
            case (mphase)
                0: if (mq.size() > 0) begin
                    mcur = mq.pop_front();
                    mphase = 1;
                    mecyc = 0;
                end
                1: begin
                    mecyc++;
                    if (fpu_data_valid) begin
                        mres = core_fn(mcur.op1, mcur.op2, mcur.sel);
                        merr = 1'b0;
                        mphase = 2;
                    end else if (mecyc == Timeout) begin
                        mres = 32'h7FC0_0000;
                        merr = 1'b1;
                        mphase = 2;
                    end
                end
                default: if (res_ready) mphase = 0;
            endcase
            if (accept) mq.push_back('{op1: cmd_op1, op2: cmd_op2, sel: cmd_sel});
        end
    end

    always @(negedge clk) begin
        chk("cmd_ready", 32'(cmd_ready), 32'(mq.size() < Depth));
        chk("cmd_count", 32'(cmd_count), 32'(mq.size()));
        chk("busy", 32'(busy), 32'(mq.size() != 0 || mphase != 0));
        chk("fpu_enable", 32'(fpu_enable), 32'(mphase == 1 && mecyc >= 1));
        chk("fpu_op1", fpu_op1, mcur.op1);
        chk("fpu_op2", fpu_op2, mcur.op2);
        chk("fpu_sel", 32'(fpu_sel), 32'(mcur.sel));
        chk("res_valid", 32'(res_valid), 32'(mphase == 2));
        chk("res_data", res_data, mres);
        chk("res_err", 32'(res_err), 32'(merr));
        if (!rst && res_valid && res_ready) begin
            got++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL order: got extra result %h want none", res_data);
            end else begin
                chk("order", res_data, sb.pop_front());
            end
        end
    end

    task automatic push_job(input logic [31:0] a, input logic [31:0] b, input logic [2:0] s,
                            input int max_wait, output bit ok);
        cmd_valid = 1'b1; cmd_op1 = a; cmd_op2 = b; cmd_sel = s;
        ok = 1'b0;
        for (int i = 0; i < max_wait && !ok; i++) begin
            @(negedge clk);
            ok = cmd_ready;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        if (ok) sb.push_back(hang ? FpuQnan : core_fn(a, b, s));
    endtask

    task automatic wait_res(input int max, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clk);
            seen = res_valid;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL res_wait: got no res_valid want one within %0d cycles", max);
        end
    endtask

    task automatic wait_idle(input int max);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < max && !idle; i++) begin
            @(negedge clk);
            idle = !busy && sb.size() == 0;
        end
        total++;
        if (!idle) begin
            bad++;
            $display("FAIL idle_wait: got busy want idle within %0d cycles", max);
        end
        @(posedge clk);
        #1;
    endtask

    bit          ok, seen, wrap_done;
    int          t0, g0;
    logic [31:0] hold;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_cmd_count", 32'(cmd_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_enable", 32'(fpu_enable), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        @(posedge clk);
        #1;

        // Single job, 1.0 + 2.0
        push_job(32'h3F80_0000, 32'h4000_0000, 3'd0, 4, ok);
        t0 = cyc;
        wait_res(20, seen);
        chk("single_latency", 32'(cyc - t0), 32'd7);
        chk("single_data", res_data, 32'h4040_0000);
        chk("single_err", 32'(res_err), 32'd0);
        wait_idle(20);

        // Stray data_valid while idle
        inj_dv = 1'b1;
        @(posedge clk);
        #1 inj_dv = 1'b0;
        @(negedge clk);
        chk("stray_res_valid", 32'(res_valid), 32'd0);
        chk("stray_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        // Fill with the result port stalled
        res_ready = 1'b0;
        for (int j = 0; j < 6; j++) begin
            push_job(32'h1000_0000 + 32'(j), 32'h0ABC_0000 + 32'(j * 7), 3'(j),
                     (j < 5) ? 2 : 3, ok);
            chk("fill_accept", 32'(ok), 32'(j < 5));
        end
        @(negedge clk);
        chk("fill_count", 32'(cmd_count), 32'd4);
        chk("fill_ready", 32'(cmd_ready), 32'd0);
        wait_res(20, seen);
        hold = res_data;
        chk("bp_first", hold, core_fn(32'h1000_0000, 32'h0ABC_0000, 3'd0));
        repeat (10) @(negedge clk);
        chk("bp_stable", res_data, hold);
        chk("bp_enable", 32'(fpu_enable), 32'd0);
        chk("bp_count", 32'(cmd_count), 32'd4);
        @(posedge clk);
        #1;
        g0 = got;
        res_ready = 1'b1;
        wait_idle(300);
        chk("fill_results", 32'(got - g0), 32'd5);

        // Watchdog expiry, then a normal job
        hang = 1'b1;
        push_job(32'h4120_0000, 32'h3F00_0000, 3'd2, 4, ok);
        t0 = cyc;
        wait_res(40, seen);
        chk("to_latency", 32'(cyc - t0), 32'd9);
        chk("to_data", res_data, 32'h7FC0_0000);
        chk("to_err", 32'(res_err), 32'd1);
        wait_idle(20);
        hang = 1'b0;
        push_job(32'h4120_0000, 32'h3F00_0000, 3'd2, 4, ok);
        wait_res(20, seen);
        chk("after_to_data", res_data, core_fn(32'h4120_0000, 32'h3F00_0000, 3'd2));
        chk("after_to_err", 32'(res_err), 32'd0);
        wait_idle(20);

        // Reset in EXEC with three jobs queued
        hang = 1'b1;
        for (int j = 0; j < 4; j++) push_job(32'h2000_0000 + 32'(j), 32'h1, 3'd1, 2, ok);
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        hang = 1'b0;
        @(negedge clk);
        chk("rst_mid_enable", 32'(fpu_enable), 32'd0);
        chk("rst_mid_count", 32'(cmd_count), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 inj_dv = 1'b1;
        @(posedge clk);
        #1 inj_dv = 1'b0;
        repeat (4) @(negedge clk);
        chk("late_dv_res_valid", 32'(res_valid), 32'd0);
        @(posedge clk);
        #1;

        // Pointer wrap with random backpressure
        g0 = got;
        wrap_done = 1'b0;
        fork
            begin
                for (int j = 0; j < 3 * Depth + 1; j++) begin
                    push_job($urandom, $urandom, 3'($urandom_range(0, 7)), 100, ok);
                    chk("wrap_push", 32'(ok), 32'd1);
                end
                wait_idle(2000);
                wrap_done = 1'b1;
            end
            begin
                while (!wrap_done) begin
                    @(posedge clk);
                    #1 res_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        res_ready = 1'b1;
        chk("wrap_results", 32'(got - g0), 32'(3 * Depth + 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        bad++;
        $display("FAIL global_timeout: got no completion want finish by 400000");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
